// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment codes, bit positions, select classes and
// the pattern-to-BCD decode used by the bus monitor (and by the display encoder).
package seg_pkg;

    localparam logic [7:0] SEG_0 = 8'h7E;
    localparam logic [7:0] SEG_1 = 8'h30;
    localparam logic [7:0] SEG_2 = 8'h6D;
    localparam logic [7:0] SEG_3 = 8'h79;
    localparam logic [7:0] SEG_4 = 8'h33;
    localparam logic [7:0] SEG_5 = 8'h5B;
    localparam logic [7:0] SEG_6 = 8'h5F;
    localparam logic [7:0] SEG_7 = 8'h70;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h7B;

    localparam int SEG_P = 7;
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [3:0] SEG_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_ONEHOT = 2'd1,
        SEL_ALL    = 2'd2
    } sel_class_e;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } flt_state_e;

    // Exact match on A..G; the decimal point is not part of the digit.
    function automatic logic [3:0] seg2bcd(input logic [6:0] seg);
        logic [3:0] bcd;
        case (seg)
            SEG_0[6:0]: bcd = 4'd0;
            SEG_1[6:0]: bcd = 4'd1;
            SEG_2[6:0]: bcd = 4'd2;
            SEG_3[6:0]: bcd = 4'd3;
            SEG_4[6:0]: bcd = 4'd4;
            SEG_5[6:0]: bcd = 4'd5;
            SEG_6[6:0]: bcd = 4'd6;
            SEG_7[6:0]: bcd = 4'd7;
            SEG_8[6:0]: bcd = 4'd8;
            SEG_9[6:0]: bcd = 4'd9;
            default:    bcd = SEG_ILLEGAL;
        endcase
        return bcd;
    endfunction

    function automatic sel_class_e sel_class(input logic [3:0] dig);
        sel_class_e cls;
        case (dig)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: cls = SEL_ONEHOT;
            4'b0000:                            cls = SEL_ALL;
            default:                            cls = SEL_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Registers the display pins once and only reports a (dig,smg) pair after it has
// been sampled unchanged STABLE_CYCLES times; emits one capture strobe per stable pattern.
module seg_stable_filter
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dig,
    input  logic [7:0] smg,
    output logic       cap_stb,
    output logic [3:0] cap_dig,
    output logic [7:0] cap_smg
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    flt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [3:0]       dig_q, prev_dig_q, cap_dig_q;
    logic [7:0]       smg_q, prev_smg_q, cap_smg_q;
    logic             cap_stb_q, cap_stb_d;
    logic             changed_s, valid_s;

    assign changed_s = ({dig_q, smg_q} != {prev_dig_q, prev_smg_q});
    assign valid_s   = (sel_class(dig_q) != SEL_NONE);
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    // State register, input stage, previous-sample copy and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            cnt_q      <= CNT_ZERO;
            dig_q      <= 4'hF;
            smg_q      <= 8'h00;
            prev_dig_q <= 4'hF;
            prev_smg_q <= 8'h00;
            cap_stb_q  <= 1'b0;
            cap_dig_q  <= 4'hF;
            cap_smg_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig;
            smg_q      <= smg;
            prev_dig_q <= dig_q;
            prev_smg_q <= smg_q;
            cap_stb_q  <= cap_stb_d;
            if (cap_stb_d) begin
                cap_dig_q <= dig_q;
                cap_smg_q <= smg_q;
            end else begin
                cap_dig_q <= cap_dig_q;
                cap_smg_q <= cap_smg_q;
            end
        end
    end

    // Next-state logic; a valid new sample always (re)starts counting at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (valid_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = (CNT_ONE == CNT_MAX) ? ST_HOLD : ST_COUNT;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_WAIT;
                end
            end
            ST_COUNT, ST_HOLD: begin
                if (!changed_s) begin
                    cnt_d   = cnt_inc_s;
                    state_d = (cnt_inc_s == CNT_MAX) ? ST_HOLD : ST_COUNT;
                end else if (valid_s) begin
                    cnt_d   = CNT_ONE;
                    state_d = (CNT_ONE == CNT_MAX) ? ST_HOLD : ST_COUNT;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_WAIT;
            end
        endcase
    end

    // Capture when the count reaches the threshold, except while resting in HOLD.
    always_comb begin
        cap_stb_d = 1'b0;
        if ((cnt_d == CNT_MAX) && ((state_q != ST_HOLD) || changed_s)) begin
            cap_stb_d = 1'b1;
        end else begin
            cap_stb_d = 1'b0;
        end
    end

    assign cap_stb = cap_stb_q;
    assign cap_dig = cap_dig_q;
    assign cap_smg = cap_smg_q;

endmodule

// File: rtl/seg_decode_mon.sv
// Passive 7-segment bus monitor: decodes captured patterns into per-digit slots and
// publishes a 4-digit frame once every digit has been seen (or on a static all-lit pattern).
module seg_decode_mon
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dig,
    input  logic [7:0]  smg,
    input  logic        err_clr,
    output logic [15:0] bcd_out,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        seg_err
);

    logic        cap_stb_s;
    logic [3:0]  cap_dig_s, dec_s;
    logic [7:0]  cap_smg_s;
    logic        dp_s;
    logic [15:0] shadow_q, shadow_d, bcd_q, bcd_d;
    logic [3:0]  dpsh_q, dpsh_d, seen_q, seen_d, dp_q, dp_d;
    logic        fv_q, fv_d, err_q, err_d;

    seg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .dig     (dig),
        .smg     (smg),
        .cap_stb (cap_stb_s),
        .cap_dig (cap_dig_s),
        .cap_smg (cap_smg_s)
    );

    assign dec_s = seg2bcd(cap_smg_s[6:0]);
    assign dp_s  = cap_smg_s[SEG_P];

    // Slot/commit/error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 16'h0000;
            dpsh_q   <= 4'h0;
            seen_q   <= 4'h0;
            bcd_q    <= 16'h0000;
            dp_q     <= 4'h0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            dpsh_q   <= dpsh_d;
            seen_q   <= seen_d;
            bcd_q    <= bcd_d;
            dp_q     <= dp_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    // Slot update and commit; the frame publishes the merged shadow including this capture.
    always_comb begin
        shadow_d = shadow_q;
        dpsh_d   = dpsh_q;
        seen_d   = seen_q;
        bcd_d    = bcd_q;
        dp_d     = dp_q;
        fv_d     = 1'b0;
        if (cap_stb_s && (cap_dig_s == 4'b0000)) begin
            shadow_d = {4{dec_s}};
            dpsh_d   = {4{dp_s}};
            bcd_d    = {4{dec_s}};
            dp_d     = {4{dp_s}};
            fv_d     = 1'b1;
            seen_d   = 4'h0;
        end else if (cap_stb_s) begin
            for (int k = 0; k < 4; k++) begin
                if (!cap_dig_s[k]) begin
                    shadow_d[k*4 +: 4] = dec_s;
                    dpsh_d[k]          = dp_s;
                    seen_d[k]          = 1'b1;
                end else begin
                    seen_d[k] = seen_q[k];
                end
            end
            if (seen_d == 4'hF) begin
                bcd_d  = shadow_d;
                dp_d   = dpsh_d;
                fv_d   = 1'b1;
                seen_d = 4'h0;
            end else begin
                fv_d = 1'b0;
            end
        end else begin
            fv_d = 1'b0;
        end
    end

    // Sticky illegal-pattern flag; a new error beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (cap_stb_s && (dec_s == SEG_ILLEGAL)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign bcd_out     = bcd_q;
    assign dp_out      = dp_q;
    assign frame_valid = fv_q;
    assign seg_err     = err_q;

endmodule

// File: tb/tb_seg_decode_mon.sv
// Directed bench for seg_decode_mon: a static-pattern decode table plus hand-built
// scan, glitch, illegal, invalid-select and reset sequences.
module tb_seg_decode_mon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dig = 4'hF;
    logic [7:0]  smg = 8'h00;
    logic        err_clr = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        seg_err;

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;

    typedef struct {
        logic [7:0] smg;
        logic [3:0] nib;
        logic       dp;
    } vec_t;

    vec_t tbl[15];

    seg_decode_mon #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig         (dig),
        .smg         (smg),
        .err_clr     (err_clr),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .seg_err     (seg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_valid) fv_cnt++;
    endtask

    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        dig = d;
        smg = s;
        repeat (n) step();
    endtask

    initial begin
        int first;
        logic exp_err;
        logic e6, e7;

        tbl[0]  = '{8'h7E, 4'd0, 1'b0};
        tbl[1]  = '{8'h30, 4'd1, 1'b0};
        tbl[2]  = '{8'h6D, 4'd2, 1'b0};
        tbl[3]  = '{8'h79, 4'd3, 1'b0};
        tbl[4]  = '{8'h33, 4'd4, 1'b0};
        tbl[5]  = '{8'h5B, 4'd5, 1'b0};
        tbl[6]  = '{8'h5F, 4'd6, 1'b0};
        tbl[7]  = '{8'h70, 4'd7, 1'b0};
        tbl[8]  = '{8'h7F, 4'd8, 1'b0};
        tbl[9]  = '{8'h7B, 4'd9, 1'b0};
        tbl[10] = '{8'hFB, 4'd9, 1'b1};
        tbl[11] = '{8'hFF, 4'd8, 1'b1};
        tbl[12] = '{8'h00, 4'hF, 1'b0};
        tbl[13] = '{8'h7C, 4'hF, 1'b0};
        tbl[14] = '{8'hBE, 4'hF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_dp", 32'(dp_out), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(seg_err), 32'h0);
        rst_n = 1'b1;
        step();

        // Static 5555: exact latency of STABLE_CYCLES+2
        fv_cnt = 0;
        first = 0;
        dig = 4'b0000;
        smg = 8'h5B;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (frame_valid && first == 0) first = c;
        end
        check("static_cycle", 32'(first), 32'd6);
        check("static_pulses", 32'(fv_cnt), 32'd1);
        check("static_bcd", 32'(bcd_out), 32'h5555);
        check("static_dp", 32'(dp_out), 32'h0);

        // Decode table in static mode
        exp_err = 1'b0;
        for (int i = 0; i < 15; i++) begin
            fv_cnt = 0;
            hold(4'b0000, tbl[i].smg, 8);
            exp_err = exp_err | (tbl[i].nib == 4'hF);
            check($sformatf("tbl%0d_pulses", i), 32'(fv_cnt), 32'd1);
            check($sformatf("tbl%0d_bcd", i), 32'(bcd_out), 32'({4{tbl[i].nib}}));
            check($sformatf("tbl%0d_dp", i), 32'(dp_out), 32'({4{tbl[i].dp}}));
            check($sformatf("tbl%0d_err", i), 32'(seg_err), 32'(exp_err));
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tbl_errclr", 32'(seg_err), 32'h0);

        // Multiplexed scan 4321
        fv_cnt = 0;
        hold(4'b1110, 8'h30, 8);
        hold(4'b1101, 8'h6D, 8);
        hold(4'b1011, 8'h79, 8);
        check("scan_partial", 32'(fv_cnt), 32'd0);
        hold(4'b0111, 8'h33, 8);
        check("scan_pulses", 32'(fv_cnt), 32'd1);
        check("scan_bcd", 32'(bcd_out), 32'h4321);

        // Glitching slot 0 must not capture until it settles
        fv_cnt = 0;
        hold(4'b1101, 8'h5B, 8);
        hold(4'b1011, 8'h5F, 8);
        hold(4'b0111, 8'h70, 8);
        for (int i = 0; i < 8; i++) hold(4'b1110, (i % 2 == 0) ? 8'h7E : 8'h30, 2);
        check("glitch_pulses", 32'(fv_cnt), 32'd0);
        check("glitch_bcd_kept", 32'(bcd_out), 32'h4321);
        hold(4'b1110, 8'h30, 8);
        check("glitch_settle_pulses", 32'(fv_cnt), 32'd1);
        check("glitch_settle_bcd", 32'(bcd_out), 32'h7651);

        // Illegal pattern, clear, then set-beats-clear
        fv_cnt = 0;
        hold(4'b0000, 8'h01, 8);
        check("illegal_bcd", 32'(bcd_out), 32'hFFFF);
        check("illegal_err", 32'(seg_err), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        check("errclr_err", 32'(seg_err), 32'h0);
        check("errclr_bcd", 32'(bcd_out), 32'hFFFF);
        err_clr = 1'b1;
        dig = 4'b0000;
        smg = 8'h02;
        e6 = 1'b0;
        e7 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 6) e6 = seg_err;
            if (c == 7) e7 = seg_err;
        end
        err_clr = 1'b0;
        check("setwins_c6", 32'(e6), 32'h1);
        check("setwins_c7", 32'(e7), 32'h0);

        // Invalid selects keep seen mask intact
        fv_cnt = 0;
        hold(4'b1110, 8'h7E, 8);
        hold(4'b1101, 8'h30, 8);
        hold(4'b1100, 8'h6D, 20);
        hold(4'b1111, 8'h6D, 20);
        check("invalid_pulses", 32'(fv_cnt), 32'd0);
        hold(4'b1011, 8'h79, 8);
        check("invalid_partial", 32'(fv_cnt), 32'd0);
        hold(4'b0111, 8'h7F, 8);
        check("invalid_pulses_end", 32'(fv_cnt), 32'd1);
        check("invalid_bcd", 32'(bcd_out), 32'h8310);

        // Reset mid-frame drops the partial frame
        hold(4'b1110, 8'h6D, 8);
        hold(4'b1101, 8'h79, 8);
        hold(4'b1011, 8'h33, 8);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(bcd_out), 32'h0);
        check("midrst_dp", 32'(dp_out), 32'h0);
        check("midrst_fv", 32'(frame_valid), 32'h0);
        dig = 4'hF;
        smg = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        fv_cnt = 0;
        hold(4'b0111, 8'h7E, 8);
        hold(4'b1011, 8'hFF, 8);
        hold(4'b1101, 8'h30, 8);
        check("postrst_partial", 32'(fv_cnt), 32'd0);
        hold(4'b1110, 8'h5B, 8);
        check("postrst_pulses", 32'(fv_cnt), 32'd1);
        check("postrst_bcd", 32'(bcd_out), 32'h0815);
        check("postrst_dp", 32'(dp_out), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
